clkswitch_req: RTL and testbench
================================

# clkswitch_req

Clock-switch requester: the initiator for the CPU clock-select handshake. It drives `hsclk_sel` into the glitch-free clock controller and watches that controller's `hsclk_selected`/`lsclk_selected` acknowledges. It decides, from the CPU access decode, when the CPU may run on the high-speed clock and when it must drop to the host (low-speed) clock. It stalls the CPU via `cpu_rdy` while a switch is in flight and flags a stuck handshake.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in each acknowledge synchroniser (min 2).
- `HOLDOFF_CYCLES`, 4: cycles with no host access that must pass in LS before a return to HS is requested.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in a transition state before the error is raised.
- `CNT_W`, 16: width of the switch counter.

Ports:
- `hsclk_in`  in  1  sole clock. All logic is on its rising edge.
- `rst_b`  in  1  reset, synchronous, active-low.
- `turbo_en`  in  1  permits HS operation. Level input.
- `access_valid`  in  1  CPU access in progress. Held stable while `cpu_rdy`=0.
- `access_host`  in  1  the access decodes to host/IO space and needs LS. Qualified by `access_valid`.
- `hsclk_selected`  in  1  acknowledge from the clock controller. Asynchronous to `hsclk_in`.
- `lsclk_selected`  in  1  acknowledge from the clock controller. Asynchronous to `hsclk_in`.
- `hsclk_sel`  out  1  request to the clock controller: 1 = HS, 0 = LS.
- `cpu_rdy`  out  1  0 stalls the CPU.
- `switch_busy`  out  1  FSM is in a transition state.
- `timeout_err`  out  1  sticky handshake-timeout flag.
- `switch_count`  out  CNT_W  completed switches, counted in both directions, saturating.

## Operation
- Both acknowledges pass through `SYNC_STAGES`-flop synchronisers, giving `hs_ack` and `ls_ack`. Nothing else uses the raw inputs.
- `host_acc` = `access_valid` & `access_host`.
- The FSM is Moore with 4 states: LS_RUN, TO_HS, HS_RUN, TO_LS.
- `hsclk_sel` = 1 in TO_HS and HS_RUN, otherwise 0. It is decoded from the state register.
- `switch_busy` = 1 in TO_HS and TO_LS.
- `cpu_rdy` is combinational:
  - 1 in LS_RUN.
  - !`host_acc` in HS_RUN.
  - 0 in TO_HS and TO_LS.
- LS_RUN:
  - `host_acc` reloads the holdoff counter with HOLDOFF_CYCLES.
  - Otherwise the counter decrements, saturating at 0.
  - Go to TO_HS when `turbo_en` & !`host_acc` & holdoff==0 & !`timeout_err`.
- TO_HS:
  - Go to HS_RUN when `hs_ack` & !`ls_ack`. `switch_count` increments.
  - The transition cannot be aborted. A `host_acc` arriving here is served by completing to HS_RUN, then going straight to TO_LS.
- HS_RUN: go to TO_LS when `host_acc` | !`turbo_en`.
- TO_LS: go to LS_RUN when `ls_ack` & !`hs_ack`. `switch_count` increments and holdoff reloads with HOLDOFF_CYCLES.
- Timeout counter:
  - Cleared on entry to any transition state.
  - Increments each cycle in a transition state, saturating.
  - Reaching TIMEOUT_CYCLES in TO_HS sets `timeout_err` and moves to TO_LS.
  - Reaching it in TO_LS sets `timeout_err`. The FSM stays in TO_LS and keeps waiting.
- `timeout_err` is sticky until reset. While it is set, LS_RUN never requests HS.
- `switch_count` holds at all-ones.
- HOLDOFF_CYCLES=0: HS is requested the first cycle the other conditions hold.

## Timing
- Reset values, applied on the rising edge with `rst_b`=0:
  - state = LS_RUN.
  - `hsclk_sel`=0, `switch_busy`=0, `timeout_err`=0, `switch_count`=0.
  - holdoff counter = HOLDOFF_CYCLES, timeout counter = 0, synchroniser flops = 0.
  - `cpu_rdy`=1, since it is combinational from LS_RUN.
- Reset mid-transition: aborted on that edge. `hsclk_sel` drops immediately; no handshake completion is waited for.
- `hsclk_sel` changes on the edge on which the FSM enters the new state.
- Acknowledge latency: an edge on an acknowledge input is visible to the FSM after `SYNC_STAGES` edges. The state changes on the following edge.
- `cpu_rdy` falls in the same cycle `host_acc` is presented in HS_RUN. It rises in the cycle LS_RUN is entered.
- Minimum HS→LS round trip with an instant acknowledge: 1 + SYNC_STAGES + 1 cycles of `cpu_rdy`=0.
- `turbo_en` dropping in TO_HS: completes to HS_RUN, then goes to TO_LS.

## Test plan
Common settings: SYNC_STAGES=2, HOLDOFF_CYCLES=4, TIMEOUT_CYCLES=64. The controller model acknowledges 3 cycles after each `hsclk_sel` change.

- Reset hold and release: `rst_b`=0 for 3 cycles, `turbo_en`=1, no accesses.
  - During reset: `hsclk_sel`=0, `cpu_rdy`=1, `timeout_err`=0, `switch_count`=0.
  - After release: `hsclk_sel` rises on the 5th edge. HS_RUN is reached and `switch_count`=1.
- Host access in HS_RUN: `access_valid`=`access_host`=1 held.
  - `cpu_rdy`=0 the same cycle; `hsclk_sel`=0 on the next edge.
  - `cpu_rdy` returns to 1 on LS_RUN entry; `switch_count`=2.
  - With the access released, HS is re-requested after 4 idle cycles.
- Holdoff restart: host accesses every 3rd cycle in LS_RUN → `hsclk_sel` stays 0 indefinitely. Gap of 5 cycles → request issued.
- Timeout: the model never asserts `hsclk_selected`.
  - 64 cycles after `hsclk_sel` rises: `timeout_err`=1 and `hsclk_sel`=0.
  - After LS is acknowledged: LS_RUN with `cpu_rdy`=1 and no further HS requests.
  - Reset clears `timeout_err`.
- Race: `host_acc` asserted 1 cycle after entering TO_HS.
  - `cpu_rdy` stays 0 through HS_RUN (1 cycle), then TO_LS.
  - `switch_count` advances by 2.
- Reset mid-TO_HS: `rst_b`=0 for 1 cycle → `hsclk_sel`=0 and `switch_count`=0 on that edge.

Source files
------------

// File: rtl/clkswitch_req.sv
`default_nettype none
// ============================================================================
//  Module   : clkswitch_req
//  Brief    : CPU clock-select handshake initiator. Requests HS/LS operation
//             from the glitch-free clock controller, stalls the CPU while a
//             switch is in flight and flags a stuck handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module clkswitch_req #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             hsclk_in,
  input  logic             rst_b,
  input  logic             turbo_en,
  input  logic             access_valid,
  input  logic             access_host,
  input  logic             hsclk_selected,
  input  logic             lsclk_selected,
  output logic             hsclk_sel,
  output logic             cpu_rdy,
  output logic             switch_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] switch_count
);

  // Counter widths sized so each counter can hold its terminal value.
  localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    TO_HS  = 2'd1,
    HS_RUN = 2'd2,
    TO_LS  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] hs_sync_q, hs_sync_d;
  logic [SYNC_STAGES-1:0] ls_sync_q, ls_sync_d;
  logic [HOLD_W-1:0]      holdoff_q, holdoff_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]       switch_count_q, switch_count_d;
  logic                   hsclk_sel_q, hsclk_sel_d;
  logic                   switch_busy_q, switch_busy_d;

  logic host_acc;
  logic hs_ack;
  logic ls_ack;
  logic cnt_inc;

  assign host_acc = access_valid & access_host;
  assign hs_ack   = hs_sync_q[SYNC_STAGES-1];
  assign ls_ack   = ls_sync_q[SYNC_STAGES-1];

  // Acknowledge synchronisers: shift the raw controller acknowledges in.
  always_comb begin
    hs_sync_d = {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected};
    ls_sync_d = {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected};
  end

  // Next-state, holdoff, timeout and switch-count logic.
  always_comb begin
    state_d        = state_q;
    holdoff_d      = holdoff_q;
    tmo_d          = tmo_q;
    timeout_err_d  = timeout_err_q;
    switch_count_d = switch_count_q;
    cnt_inc        = 1'b0;

    case (state_q)
      LS_RUN: begin
        if (host_acc) begin
          holdoff_d = HOLD_INIT;
        end else if (holdoff_q != '0) begin
          holdoff_d = holdoff_q - 1'b1;
        end
        // Uses the pre-edge holdoff so HOLDOFF_CYCLES=0 requests at once.
        if (turbo_en && !host_acc && (holdoff_q == '0) && !timeout_err_q) begin
          state_d = TO_HS;
          tmo_d   = '0;
        end
      end
      TO_HS: begin
        if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + 1'b1;
        end
        // A completed handshake wins over a simultaneous timeout.
        if (hs_ack && !ls_ack) begin
          state_d = HS_RUN;
          cnt_inc = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = TO_LS;
          tmo_d         = '0;
        end
      end
      HS_RUN: begin
        if (host_acc || !turbo_en) begin
          state_d = TO_LS;
          tmo_d   = '0;
        end
      end
      TO_LS: begin
        if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + 1'b1;
        end
        // No escape from TO_LS: the CPU cannot run until LS is confirmed.
        if (ls_ack && !hs_ack) begin
          state_d   = LS_RUN;
          cnt_inc   = 1'b1;
          holdoff_d = HOLD_INIT;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = LS_RUN;
      end
    endcase

    if (cnt_inc && (switch_count_q != '1)) begin
      switch_count_d = switch_count_q + 1'b1;
    end

    // Outputs registered alongside the state so they change on entry.
    hsclk_sel_d   = (state_d == TO_HS) || (state_d == HS_RUN);
    switch_busy_d = (state_d == TO_HS) || (state_d == TO_LS);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge hsclk_in) begin
    if (!rst_b) begin
      state_q        <= LS_RUN;
      hs_sync_q      <= '0;
      ls_sync_q      <= '0;
      holdoff_q      <= HOLD_INIT;
      tmo_q          <= '0;
      timeout_err_q  <= 1'b0;
      switch_count_q <= '0;
      hsclk_sel_q    <= 1'b0;
      switch_busy_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hs_sync_q      <= hs_sync_d;
      ls_sync_q      <= ls_sync_d;
      holdoff_q      <= holdoff_d;
      tmo_q          <= tmo_d;
      timeout_err_q  <= timeout_err_d;
      switch_count_q <= switch_count_d;
      hsclk_sel_q    <= hsclk_sel_d;
      switch_busy_q  <= switch_busy_d;
    end
  end

  // CPU ready: free in LS, stalled by host accesses in HS, held in transitions.
  always_comb begin
    case (state_q)
      LS_RUN:  cpu_rdy = 1'b1;
      HS_RUN:  cpu_rdy = !host_acc;
      default: cpu_rdy = 1'b0;
    endcase
  end

  assign hsclk_sel    = hsclk_sel_q;
  assign switch_busy  = switch_busy_q;
  assign timeout_err  = timeout_err_q;
  assign switch_count = switch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_clkswitch_req.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clkswitch_req
//  Brief    : Directed self-checking bench for clkswitch_req with a clock
//             controller model that acknowledges 3 cycles after each request.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clkswitch_req;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        turbo_en;
  logic        access_valid;
  logic        access_host;
  logic        hsclk_selected;
  logic        lsclk_selected;
  logic        hsclk_sel;
  logic        cpu_rdy;
  logic        switch_busy;
  logic        timeout_err;
  logic [15:0] switch_count;

  int tests = 0;
  int fails = 0;

  // Controller model: 3-cycle delay line on the request, HS ack can be blocked.
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  logic d3 = 1'b0;
  logic block_hs = 1'b0;

  always #5 clk = ~clk;

  // Delay line for the controller acknowledge model.
  always @(posedge clk) begin
    d1 <= hsclk_sel;
    d2 <= d1;
    d3 <= d2;
  end

  assign hsclk_selected = d3 & ~block_hs;
  assign lsclk_selected = ~d3;

  clkswitch_req #(
    .SYNC_STAGES   (2),
    .HOLDOFF_CYCLES(4),
    .TIMEOUT_CYCLES(64),
    .CNT_W         (16)
  ) dut (
    .hsclk_in      (clk),
    .rst_b         (rst_b),
    .turbo_en      (turbo_en),
    .access_valid  (access_valid),
    .access_host   (access_host),
    .hsclk_selected(hsclk_selected),
    .lsclk_selected(lsclk_selected),
    .hsclk_sel     (hsclk_sel),
    .cpu_rdy       (cpu_rdy),
    .switch_busy   (switch_busy),
    .timeout_err   (timeout_err),
    .switch_count  (switch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a given {hsclk_sel, switch_busy} pair.
  task automatic wait_mode(input string tag, input logic sel, input logic busy);
    int n;
    n = 0;
    while (!(hsclk_sel === sel && switch_busy === busy) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {30'd0, hsclk_sel, switch_busy}, {30'd0, sel, busy});
  endtask

  // Bounded wait for the HS request to rise.
  task automatic wait_sel_rise(input string tag);
    int n;
    n = 0;
    while (hsclk_sel !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, hsclk_sel}, 32'd1);
  endtask

  task automatic set_access(input logic v);
    access_valid = v;
    access_host  = v;
  endtask

  initial begin
    rst_b    = 1'b0;
    turbo_en = 1'b1;
    set_access(1'b0);

    // Reset hold: 3 cycles with outputs at their reset values.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sel",   {31'd0, hsclk_sel},   32'd0);
      chk("rst_rdy",   {31'd0, cpu_rdy},     32'd1);
      chk("rst_err",   {31'd0, timeout_err}, 32'd0);
      chk("rst_count", {16'd0, switch_count}, 32'd0);
    end
    rst_b = 1'b1;

    // Holdoff of 4 after release: request appears on the 5th edge.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rel_sel_low", {31'd0, hsclk_sel}, 32'd0);
    end
    tick();
    chk("rel_sel_rise", {30'd0, hsclk_sel, switch_busy}, 32'd3);
    chk("rel_rdy_stall", {31'd0, cpu_rdy}, 32'd0);
    wait_mode("reach_hs_1", 1'b1, 1'b0);
    chk("count_1", {16'd0, switch_count}, 32'd1);
    chk("hs_rdy_idle", {31'd0, cpu_rdy}, 32'd1);

    // Host access in HS_RUN: immediate stall, request drops next edge.
    set_access(1'b1);
    #1;
    chk("hs_host_stall", {31'd0, cpu_rdy}, 32'd0);
    tick();
    chk("to_ls_sel", {30'd0, hsclk_sel, switch_busy}, 32'd1);
    chk("to_ls_rdy", {31'd0, cpu_rdy}, 32'd0);
    wait_mode("reach_ls_2", 1'b0, 1'b0);
    chk("ls_rdy_back", {31'd0, cpu_rdy}, 32'd1);
    chk("count_2", {16'd0, switch_count}, 32'd2);
    set_access(1'b0);

    // HS re-requested after 4 idle cycles.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_sel_low", {31'd0, hsclk_sel}, 32'd0);
    end
    tick();
    chk("idle_sel_rise", {31'd0, hsclk_sel}, 32'd1);
    wait_mode("reach_hs_3", 1'b1, 1'b0);
    chk("count_3", {16'd0, switch_count}, 32'd3);

    // Dropping turbo_en returns to LS.
    turbo_en = 1'b0;
    wait_mode("reach_ls_4", 1'b0, 1'b0);
    chk("count_4", {16'd0, switch_count}, 32'd4);
    turbo_en = 1'b1;

    // Holdoff restart: host access every 3rd cycle keeps LS.
    for (int i = 0; i < 30; i++) begin
      set_access(i % 3 == 0);
      tick();
      chk("holdoff_hold", {31'd0, hsclk_sel}, 32'd0);
    end
    set_access(1'b0);
    tick();
    chk("gap_sel_low_3", {31'd0, hsclk_sel}, 32'd0);
    tick();
    chk("gap_sel_low_4", {31'd0, hsclk_sel}, 32'd0);
    tick();
    chk("gap_sel_rise", {31'd0, hsclk_sel}, 32'd1);
    wait_mode("reach_hs_5", 1'b1, 1'b0);
    chk("count_5", {16'd0, switch_count}, 32'd5);

    turbo_en = 1'b0;
    wait_mode("reach_ls_6", 1'b0, 1'b0);
    chk("count_6", {16'd0, switch_count}, 32'd6);
    turbo_en = 1'b1;

    // Race: host access one cycle after entering TO_HS.
    wait_sel_rise("race_sel_rise");
    tick();
    set_access(1'b1);
    begin
      int n;
      n = 0;
      while (!(hsclk_sel === 1'b1 && switch_busy === 1'b0) && n < 40) begin
        chk("race_stall", {31'd0, cpu_rdy}, 32'd0);
        tick();
        n++;
      end
    end
    chk("race_hs", {30'd0, hsclk_sel, switch_busy}, 32'd2);
    chk("race_hs_rdy", {31'd0, cpu_rdy}, 32'd0);
    chk("count_7", {16'd0, switch_count}, 32'd7);
    tick();
    chk("race_to_ls", {30'd0, hsclk_sel, switch_busy}, 32'd1);
    chk("race_to_ls_rdy", {31'd0, cpu_rdy}, 32'd0);
    wait_mode("race_reach_ls", 1'b0, 1'b0);
    chk("count_8", {16'd0, switch_count}, 32'd8);
    set_access(1'b0);

    // Reset in the middle of TO_HS aborts the switch on that edge.
    wait_sel_rise("mid_sel_rise");
    tick();
    rst_b = 1'b0;
    tick();
    chk("mid_rst_sel",   {30'd0, hsclk_sel, switch_busy}, 32'd0);
    chk("mid_rst_count", {16'd0, switch_count}, 32'd0);
    chk("mid_rst_rdy",   {31'd0, cpu_rdy}, 32'd1);
    rst_b = 1'b1;

    // Timeout: controller never confirms HS.
    block_hs = 1'b1;
    wait_sel_rise("tmo_sel_rise");
    for (int i = 0; i < 63; i++) begin
      tick();
      chk("tmo_waiting", {30'd0, hsclk_sel, timeout_err}, 32'd2);
    end
    tick();
    chk("tmo_fire", {30'd0, hsclk_sel, timeout_err}, 32'd1);
    wait_mode("tmo_reach_ls", 1'b0, 1'b0);
    chk("tmo_ls_rdy",   {31'd0, cpu_rdy}, 32'd1);
    chk("tmo_sticky",   {31'd0, timeout_err}, 32'd1);
    chk("tmo_count",    {16'd0, switch_count}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("tmo_no_req", {31'd0, hsclk_sel}, 32'd0);
    end
    rst_b = 1'b0;
    tick();
    chk("tmo_rst_clear", {31'd0, timeout_err}, 32'd0);
    rst_b = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
